// File: rtl/write_demux_4way.sv
// Steers one write word to one of four targets, each behind its own 2-entry FIFO; WRITE_DEMUX_COUNT_EN adds per-target accept counters.
// Latency: a word accepted at edge k is presented at its target after edge k.
// Backpressure: in_ready is low while the selected target's FIFO is full, during flush and during rst.

module write_demux_4way_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);
  logic [W-1:0] r_mem [2];
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_occ;

  assign o_full = (r_occ == 2'd2);
  assign o_vld  = (r_occ != 2'd0);
  assign o_dat  = r_mem[r_head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= 2'd0;
    end else if (i_flush) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (i_push) r_tail <= ~r_tail;
      if (i_pop)  r_head <= ~r_head;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed behind o_vld.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_dat;
  end
endmodule

module write_demux_4way #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_select,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [DATA_WIDTH-1:0]  out_data0,
  output logic [DATA_WIDTH-1:0]  out_data1,
  output logic [DATA_WIDTH-1:0]  out_data2,
  output logic [DATA_WIDTH-1:0]  out_data3,
  output logic [4*CNT_WIDTH-1:0] xfer_count
);
  logic [3:0]            w_full;
  logic [3:0]            w_push;
  logic [3:0]            w_pop;
  logic [DATA_WIDTH-1:0] w_dat [4];

  // No pass-through: a full target stays not-ready even if its head pops this cycle.
  assign in_ready = !rst && !flush && !w_full[in_select];
  assign w_pop    = out_valid & out_ready;

  always_comb begin
    w_push            = 4'b0000;
    w_push[in_select] = in_valid & in_ready;
  end

  for (genvar g = 0; g < 4; g++) begin : g_tgt
    write_demux_4way_fifo #(.W(DATA_WIDTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_push[g]),
      .i_dat   (in_data),
      .i_pop   (w_pop[g]),
      .o_full  (w_full[g]),
      .o_vld   (out_valid[g]),
      .o_dat   (w_dat[g])
    );
  end

  assign out_data0 = w_dat[0];
  assign out_data1 = w_dat[1];
  assign out_data2 = w_dat[2];
  assign out_data3 = w_dat[3];

`ifdef WRITE_DEMUX_COUNT_EN
  logic [CNT_WIDTH-1:0] r_cnt [4];

  // w_push is already masked by flush, so a flushed cycle never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    xfer_count = '0;
    for (int i = 0; i < 4; i++) xfer_count[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
  end
`else
  assign xfer_count = '0;
`endif
endmodule

// File: tb/tb_write_demux_4way.sv
// Bench for write_demux_4way: directed scenarios plus random traffic checked against per-target queues.
// Inputs change on the falling edge; outputs are sampled 1ns after either edge.

module tb_write_demux_4way;
  localparam int DW = 32;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_select;
  logic [DW-1:0]    in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [DW-1:0]    out_data0, out_data1, out_data2, out_data3;
  logic [4*CW-1:0]  xfer_count;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mq [4][$];
  logic [CW-1:0] mcnt [4];

  write_demux_4way #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] exp_valid();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() > 0);
    return r;
  endfunction

  function automatic logic exp_ready();
    return !rst && !flush && (mq[in_select].size() < 2);
  endfunction

  function automatic logic [4*CW-1:0] exp_cnt();
    logic [4*CW-1:0] r;
    r = '0;
`ifdef WRITE_DEMUX_COUNT_EN
    for (int i = 0; i < 4; i++) r[i*CW +: CW] = mcnt[i];
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] obs_data(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mcnt[i] = '0;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                       input logic [3:0] ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_select = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Advances one rising edge and applies the same edge to the reference queues.
  task automatic tick();
    logic       acc;
    logic [3:0] pop;
    acc = in_valid && exp_ready();
    pop = out_ready & exp_valid();
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) if (pop[i]) void'(mq[i].pop_front());
      if (acc) begin
        mq[in_select].push_back(in_data);
        mcnt[in_select] = mcnt[in_select] + 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_select = 2'd0; in_data = '0; out_ready = 4'b0;
    model_clear();
    drive(1'b0, 2'd0, '0, 4'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_out_valid: got %b want 0000", out_valid); end
    checks++; if (xfer_count !== '0) begin failures++; $display("FAIL reset_xfer_count: got %h want 0", xfer_count); end
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 2'd1, 32'h1001, 4'b0, 1'b0); tick();
    drive(1'b1, 2'd1, 32'h1002, 4'b0, 1'b0); tick();
    drive(1'b0, 2'd1, '0, 4'b0, 1'b0);
    checks++; if (out_valid !== 4'b0010) begin failures++; $display("FAIL burst_queued: got %b want 0010", out_valid); end
    rst = 1'b1;
    #1;
    model_clear();
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL async_rst_valid: got %b want 0000", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL async_rst_ready: got %b want 0", in_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
    checks++; if (xfer_count !== '0) begin failures++; $display("FAIL post_rst_count: got %h want 0", xfer_count); end
  endtask

  task automatic test_steering();
    logic [DW-1:0] vals [4];
    vals = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), vals[i], 4'b0, 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, '0, 4'b0, 1'b0);
    checks++; if (out_valid !== 4'b1111) begin failures++; $display("FAIL steer_valid: got %b want 1111", out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_data(i) !== vals[i]) begin failures++; $display("FAIL steer_data%0d: got %h want %h", i, obs_data(i), vals[i]); end
    end
    checks++; if (xfer_count !== exp_cnt()) begin failures++; $display("FAIL steer_count: got %h want %h", xfer_count, exp_cnt()); end
    drive(1'b0, 2'd0, '0, 4'b1111, 1'b0); tick();
  endtask

  task automatic test_full();
    drive(1'b1, 2'd2, 32'h11, 4'b0, 1'b0); tick();
    drive(1'b1, 2'd2, 32'h22, 4'b0, 1'b0); tick();
    drive(1'b1, 2'd2, 32'h33, 4'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_sel2: got %b want 0", in_ready); end
    tick();
    drive(1'b0, 2'd0, '0, 4'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_sel0: got %b want 1", in_ready); end
    drive(1'b1, 2'd2, 32'h33, 4'b0100, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_no_passthru: got %b want 0", in_ready); end
    checks++; if (out_data2 !== 32'h11) begin failures++; $display("FAIL full_first: got %h want 00000011", out_data2); end
    tick();
    drive(1'b0, 2'd2, '0, 4'b0100, 1'b0);
    checks++; if (out_data2 !== 32'h22) begin failures++; $display("FAIL full_second: got %h want 00000022", out_data2); end
    tick();
    drive(1'b0, 2'd2, '0, 4'b0100, 1'b0);
    checks++; if (out_valid[2] !== 1'b0) begin failures++; $display("FAIL full_drained: got %b want 0", out_valid[2]); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] got [$];
    for (int k = 0; k < 10; k++) begin
      drive(k < 8, 2'd3, DW'(k + 1), 4'b1000, 1'b0);
      if (k < 8) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_stall%0d: got %b want 1", k, in_ready); end
      end
      checks++;
      if (out_valid !== exp_valid()) begin failures++; $display("FAIL stream_valid%0d: got %b want %b", k, out_valid, exp_valid()); end
      if (out_valid[3]) got.push_back(out_data3);
      tick();
    end
    checks++; if (got.size() != 8) begin failures++; $display("FAIL stream_count: got %0d want 8", got.size()); end
    for (int j = 0; j < got.size() && j < 8; j++) begin
      checks++;
      if (got[j] !== DW'(j + 1)) begin failures++; $display("FAIL stream_order%0d: got %h want %h", j, got[j], DW'(j + 1)); end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 2'd0, 32'hAA, 4'b0, 1'b0); tick();
    drive(1'b1, 2'd1, 32'hBB, 4'b0, 1'b0); tick();
    drive(1'b1, 2'd2, 32'hCC, 4'b0, 1'b0); tick();
    drive(1'b1, 2'd0, 32'h55, 4'b1111, 1'b1);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'd0, '0, 4'b1111, 1'b0);
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL flush_valid%0d: got %b want 0000", k, out_valid); end
      tick();
    end
    checks++; if (xfer_count !== exp_cnt()) begin failures++; $display("FAIL flush_count: got %h want %h", xfer_count, exp_cnt()); end
  endtask

  task automatic test_counter_wrap();
    logic [4*CW-1:0] want;
    @(negedge clk); rst = 1'b1; #1; model_clear();
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 2'd1, DW'(k), 4'b0010, 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, '0, 4'b0, 1'b0);
`ifdef WRITE_DEMUX_COUNT_EN
    want = 16'h0010;
`else
    want = 16'h0000;
`endif
    checks++; if (xfer_count !== want) begin failures++; $display("FAIL count_wrap: got %h want %h", xfer_count, want); end
    checks++; if (xfer_count !== exp_cnt()) begin failures++; $display("FAIL count_model: got %h want %h", xfer_count, exp_cnt()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), DW'($urandom),
            4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
      checks++;
      if (in_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready%0d: got %b want %b", k, in_ready, exp_ready()); end
      tick();
      checks++;
      if (out_valid !== exp_valid()) begin failures++; $display("FAIL rand_valid%0d: got %b want %b", k, out_valid, exp_valid()); end
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() > 0) begin
          checks++;
          if (obs_data(i) !== mq[i][0]) begin failures++; $display("FAIL rand_data%0d_t%0d: got %h want %h", k, i, obs_data(i), mq[i][0]); end
        end
      end
      checks++;
      if (xfer_count !== exp_cnt()) begin failures++; $display("FAIL rand_count%0d: got %h want %h", k, xfer_count, exp_cnt()); end
    end
  endtask

  initial begin
    test_reset();
    test_steering();
    test_full();
    test_streaming();
    test_flush();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/write_demux_4way.md
# write_demux_4way

Single-initiator to four-target write demultiplexer for the SCPU datapath. It takes one data word plus a 2-bit target select and steers the word to one of four target ports, the opposite of the datapath's four-way select muxes. Each target port has its own 2-entry FIFO and valid/ready handshake, so one stalled target does not lose data. It sits between the CPU store path and the memory-mapped I/O targets.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: width of the data word.
- `CNT_WIDTH`, default 16: width of each per-target transfer counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all FIFOs.
- `in_valid`  in  1  the initiator presents a word.
- `in_ready`  out  1  the demux accepts the word this cycle.
- `in_select`  in  2  target index, 0..3.
- `in_data`  in  DATA_WIDTH  word to forward.
- `out_valid`  out  4  bit i: the head of target i's FIFO is valid.
- `out_ready`  in  4  bit i: target i consumes its head this cycle.
- `out_data0`..`out_data3`  out  DATA_WIDTH each  FIFO head for target 0..3.
- `xfer_count`  out  4*CNT_WIDTH  accepted-word counters; target i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].

## Operation

- Four independent 2-entry FIFOs, one per target. Each has a 2-bit occupancy (0..2), a head pointer and a tail pointer.
- `in_ready` is combinational:
  - 1 when target `in_select`'s FIFO is not full and `flush` is 0.
  - 0 otherwise, including while `rst` is high.
- Accept: `in_valid & in_ready` at a clock edge writes `in_data` into FIFO[`in_select`].
- Pop: `out_valid[i] & out_ready[i]` at a clock edge retires the head of FIFO i. `out_ready[i]` while `out_valid[i]` is 0 has no effect.
- `out_valid[i]` is 1 exactly when occupancy[i] is greater than 0.
- `out_dataN` shows the FIFO head. It is don't-care when `out_valid[N]` is 0, but must be stable while valid and not popped.
- Push and pop on the same FIFO in one cycle: occupancy is unchanged, FIFO order is kept, and the pushed word becomes the tail.
- A full FIFO with the head popping this cycle still deasserts `in_ready`. There is no same-cycle pass-through into a full FIFO.
- Pops and a push to different targets proceed concurrently. All four targets may pop in the same cycle.
- Words to the same target are delivered in acceptance order. There is no ordering between targets.
- `flush`: at the next edge all occupancies and pointers go to 0. Any push or pop in that cycle is discarded. `flush` has priority over all other events.
- The target index never goes out of range; all four values of `in_select` are valid.

## Timing

- Reset values: `in_ready`=0 while `rst` is high; `out_valid`=4'b0000; FIFO pointers, occupancies and `xfer_count` = 0. `out_dataN` contents are don't-care.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Queued words are lost.
- Latency: a word accepted at edge k gives `out_valid[sel]`=1 after edge k, provided the FIFO was empty.
- Throughput: one word per cycle into any single target, sustained while that target holds `out_ready` high.
- The `in_select` → `in_ready` path is combinational. The initiator must hold `in_select` and `in_data` stable while `in_valid` is high and `in_ready` is low.

## Configuration

- `WRITE_DEMUX_COUNT_EN` defined:
  - Each target has a `CNT_WIDTH` counter that increments on every accepted word for that target.
  - The counter wraps from all-ones to 0.
  - It is cleared only by `rst`; `flush` does not clear it.
- `WRITE_DEMUX_COUNT_EN` undefined:
  - No counter logic is built.
  - `xfer_count` is tied to 0.

## Test plan

- **Reset:** assert `rst` mid-burst with 2 words queued in target 1 → `out_valid`=0000 and `in_ready`=0 immediately; after release `in_ready`=1 and `xfer_count`=0.
- **Steering:** push 0xA0 (sel 0), 0xB1 (sel 1), 0xC2 (sel 2), 0xD3 (sel 3) with every `out_ready`=0 → `out_valid`=1111 and `out_data0..3` = 0xA0, 0xB1, 0xC2, 0xD3.
- **Full FIFO:** push 0x11, 0x22 to target 2 with `out_ready[2]`=0 → `in_ready`=0 while sel=2 and 1 while sel=0. Raise `out_ready[2]` → 0x11 then 0x22 are delivered and `in_ready` returns to 1.
- **Streaming:** 8 consecutive words 1..8 to target 3 with `out_ready[3]`=1 continuously → no stall cycles, words 1..8 received in order, occupancy never exceeds 1.
- **Flush priority:** `flush`=1 in the same cycle as `in_valid`=1 (sel 0, data 0x55) and `out_ready`=1111 with 3 targets holding words → next cycle `out_valid`=0000; 0x55 is never delivered; `xfer_count` is unchanged when `WRITE_DEMUX_COUNT_EN` is defined.
- **Counter wrap (`WRITE_DEMUX_COUNT_EN`, `CNT_WIDTH`=4):** push 17 words to target 1 → that counter reads 1 and the other three read 0.
